display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Scan controller and scheduler for the four-digit seven-segment display on the matrix multiplier board. It paces digit multiplexing with a refresh prescaler and inserts an anti-ghosting blank interval in every digit slot. It holds one loaded 2x2 result matrix of four 16-bit elements and chooses which element is shown, either on request or by auto-cycling. New results are applied only at frame boundaries, so the display never tears.

## Interface
Parameters:
- PRESCALE, 1000: clk cycles per digit slot (≥ 4).
- BLANK, 16: cycles at the start of each slot with all anodes off (1 ≤ BLANK < PRESCALE).
- DWELL_FRAMES, 256: frames per element in auto mode (≥ 1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- load  in  1  one-cycle pulse; capture `result`.
- result  in  64  element k at [16k+15:16k], k = 0..3.
- auto  in  1  level; 1 = auto-cycle elements.
- next  in  1  one-cycle pulse; request advance to next element. Already debounced upstream.
- an  out  4  anode enables, active-low, registered.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- elem_idx  out  2  index of the displayed element.
- frame_tick  out  1  one-cycle pulse at the end of each frame.

## Operation
- **Prescaler `cnt`:** runs 0..PRESCALE-1 and wraps. The slot ends on the cycle where cnt = PRESCALE-1.
- **Digit counter `sel`:** 2 bits, advances at slot end and wraps 3→0.
- **frame_tick:** asserted (registered) in the cycle after the slot end that has sel = 3.
- **Pending buffer:** load writes `result` into `pend` and sets `pend_v`. A load while pend_v = 1 overwrites `pend`, last writer wins.
- **Element FSM, EMPTY:** the reset state.
  - All digits show a dash, seg = 0111111, and dp is off.
  - next and auto are ignored.
  - At a frame end with pend_v = 1: copy pend → disp, clear pend_v, set elem_idx = 0 and dwell = 0, go to SHOW.
- **Element FSM, SHOW:**
  - At a frame end with pend_v = 1: same transfer as above, and elem_idx returns to 0. The transfer takes priority over any next or auto advance in that frame.
  - A `next` pulse sets `nreq`. At the frame end, nreq advances elem_idx by 1 (mod 4), clears nreq and zeroes dwell.
  - Auto = 1 and no nreq: dwell increments at each frame end. When dwell = DWELL_FRAMES-1, elem_idx advances and dwell resets to 0.
  - Auto = 0: dwell holds at 0.
- **Simultaneous events:**
  - load in the same cycle as the frame-end transfer: the incoming `result` goes directly to disp, and pend_v stays 0.
  - next in the same cycle as a frame end: it takes effect at that frame end.
- **Digit mapping:**
  - sel = s drives an = ~(1<<s), showing nibble disp[elem_idx][4s+3:4s].
  - Hex decode, active-low: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- **dp:** lit (0) on the digit where sel = elem_idx, as a position marker. Only in SHOW.

## Timing
- **Reset values:** while rst = 0 and on its release:
  - cnt = 0, sel = 0, state EMPTY.
  - an = 1111, seg = 1111111, dp = 1.
  - elem_idx = 0, frame_tick = 0.
  - pend_v = 0, nreq = 0, dwell = 0.
- **Reset mid-operation:** asserting rst drops everything to the values above immediately, and a pending load is lost.
- **Output latency:** an/seg/dp are registered one cycle behind cnt/sel.
- **Blanking:** an = 1111 for the BLANK cycles following each slot boundary. For the remaining PRESCALE-BLANK cycles, the selected anode is low. seg is don't-care-stable (the decoded value) while blanked.
- **Frame:** 4·PRESCALE cycles. frame_tick has period 4·PRESCALE, and the first tick comes 4·PRESCALE cycles after reset release.
- **Visibility latency:** new data, an element advance or an auto advance becomes visible starting with digit 0 of the next frame. The slot boundary after frame_tick is the first one to use it.
- **Auto dwell:** in auto mode each element is shown for exactly DWELL_FRAMES frames.

## Test plan
Parameters for all cases: PRESCALE = 8, BLANK = 2, DWELL_FRAMES = 3.

1. **Reset and empty display.** Release rst with no load → an cycles 1110, 1101, 1011, 0111, each low 6 of 8 cycles. seg = 0111111, dp = 1, frame_tick every 32 cycles.
2. **Load and first element.** load result = 64'h0000_0000_0000_A3F1 → from the next frame, digits 0..3 show 1, F, 3, A (1111001, 0001110, 0110000, 0001000). elem_idx = 0, dp low on digit 0.
3. **Manual advance.** In SHOW, pulse next mid-frame → elem_idx changes to 1 only after frame_tick, and dp moves to digit 1. Two pulses within one frame → a single advance.
4. **Auto cycling.** Hold auto = 1 → elem_idx sequence 0, 1, 2, 3, 0, with each value held 3 frames (96 cycles). A next pulse restarts the 3-frame dwell.
5. **Load boundary conditions.**
   - Two loads within one frame (values X then Y) → Y is displayed and elem_idx = 0.
   - A load in the frame_tick transfer cycle → applied at that boundary, and pend_v = 0 afterwards.
6. **Reset mid-frame.** Assert rst at cnt = 5, sel = 2, in SHOW → an = 1111, seg = 1111111 immediately. After release, the display is back in EMPTY showing dashes.

Source files
------------

// File: rtl/display_scan_controller_if.sv
// Bus bundle between the result source and the seven-segment scan controller.
// The controller side (slave) takes result/control inputs and drives the display outputs.
interface display_scan_controller_if;
    logic        load;
    logic [63:0] result;
    logic        auto;
    logic        next;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  elem_idx;
    logic        frame_tick;

    modport master (
        output load, result, auto, next,
        input  an, seg, dp, elem_idx, frame_tick
    );

    modport slave (
        input  load, result, auto, next,
        output an, seg, dp, elem_idx, frame_tick
    );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan controller with per-slot blanking and frame-aligned
// selection of one element out of a buffered 2x2 matrix of 16-bit results.
module display_scan_controller #(
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK        = 16,
    parameter int unsigned DWELL_FRAMES = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    display_scan_controller_if.slave    bus
);

    localparam int unsigned CNT_W   = $clog2(PRESCALE);
    localparam int unsigned DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]   CNT_BLANK  = CNT_W'(BLANK);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [1:0]         sel_q,    sel_d;
    logic [0:0]         state_q,  state_d;
    logic [63:0]        pend_q,   pend_d;
    logic               pend_v_q, pend_v_d;
    logic               nreq_q,   nreq_d;
    logic [63:0]        disp_q,   disp_d;
    logic [1:0]         elem_q,   elem_d;
    logic [DWELL_W-1:0] dwell_q,  dwell_d;
    logic [3:0]         an_q,     an_d;
    logic [6:0]         seg_q,    seg_d;
    logic               dp_q,     dp_d;
    logic               tick_q,   tick_d;

    logic               slot_end;
    logic               frame_end;
    logic [3:0]         nibble;

    // Active-low hex decode, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        hex7 = SEG_OFF;
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            4'hF: hex7 = 7'b0001110;
            default: hex7 = SEG_OFF;
        endcase
    endfunction

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (sel_q == 2'd3);
    assign nibble    = disp_q[{elem_q, sel_q, 2'b00} +: 4];

    // State register: counters, element FSM, buffers and registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            state_q  <= ST_EMPTY;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            nreq_q   <= 1'b0;
            disp_q   <= '0;
            elem_q   <= 2'd0;
            dwell_q  <= '0;
            an_q     <= 4'b1111;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            nreq_q   <= nreq_d;
            disp_q   <= disp_d;
            elem_q   <= elem_d;
            dwell_q  <= dwell_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
        sel_d    = slot_end ? sel_q + 2'd1 : sel_q;
        state_d  = state_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        nreq_d   = nreq_q;
        disp_d   = disp_q;
        elem_d   = elem_q;
        dwell_d  = dwell_q;

        if (bus.load) begin
            pend_d   = bus.result;
            pend_v_d = 1'b1;
        end
        if ((state_q == ST_SHOW) && bus.next) begin
            nreq_d = 1'b1;
        end

        // Frame boundary: a coincident load bypasses the pending buffer straight to disp.
        if (frame_end) begin
            if (pend_v_q || bus.load) begin
                disp_d   = bus.load ? bus.result : pend_q;
                pend_v_d = 1'b0;
                state_d  = ST_SHOW;
                elem_d   = 2'd0;
                dwell_d  = '0;
                nreq_d   = 1'b0;
            end else if (state_q == ST_SHOW) begin
                if (nreq_q || bus.next) begin
                    elem_d  = elem_q + 2'd1;
                    nreq_d  = 1'b0;
                    dwell_d = '0;
                end else if (bus.auto) begin
                    if (dwell_q == DWELL_LAST) begin
                        elem_d  = elem_q + 2'd1;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end else begin
                    dwell_d = '0;
                end
            end
        end

        an_d   = (cnt_q < CNT_BLANK) ? 4'b1111 : ~(4'b0001 << sel_q);
        seg_d  = (state_q == ST_SHOW) ? hex7(nibble) : SEG_DASH;
        dp_d   = !((state_q == ST_SHOW) && (sel_q == elem_q));
        tick_d = frame_end;
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.elem_idx   = elem_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: a frame-level reference model pushes the
// expected output snapshot each cycle and the sampled DUT outputs are popped against it.
module tb_display_scan_controller;

    typedef struct {
        string       tag;
        logic [14:0] val;
    } exp_t;

    localparam logic [14:0] SNAP_RST = {4'b1111, 7'b1111111, 1'b1, 2'd0, 1'b0};

    logic clk;
    logic rst;

    display_scan_controller_if bus ();

    display_scan_controller #(
        .PRESCALE    (8),
        .BLANK       (2),
        .DWELL_FRAMES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          compared   = 0;
    int          mismatched = 0;
    exp_t        sb[$];
    string       phase;
    logic [6:0]  hex_tab [16];

    // Reference model state (what the display should hold during the current frame).
    int          cyc;
    bit          m_show;
    logic [63:0] m_disp;
    logic [63:0] m_pend;
    bit          m_pend_v;
    bit          m_nreq;
    logic [1:0]  m_elem;
    int          m_dwell;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [14:0] snap();
        return {bus.an, bus.seg, bus.dp, bus.elem_idx, bus.frame_tick};
    endfunction

    task automatic model_reset();
        cyc      = 0;
        m_show   = 0;
        m_disp   = '0;
        m_pend   = '0;
        m_pend_v = 0;
        m_nreq   = 0;
        m_elem   = 2'd0;
        m_dwell  = 0;
    endtask

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // One clock: predict, push, clock, sample, pop and compare; then drop one-cycle pulses.
    task automatic step();
        exp_t       e;
        int         cnt_m;
        logic [1:0] sel_m;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        logic       fe;
        int         idx;

        cnt_m = cyc % 8;
        sel_m = 2'((cyc / 8) % 4);
        fe    = (cnt_m == 7) && (sel_m == 2'd3);
        an_e  = (cnt_m < 2) ? 4'b1111 : ~(4'b0001 << sel_m);
        idx   = int'(m_elem) * 16 + int'(sel_m) * 4;
        seg_e = m_show ? hex_tab[m_disp[idx +: 4]] : 7'b0111111;
        dp_e  = !(m_show && (sel_m == m_elem));

        if (fe) begin
            if (m_pend_v || bus.load) begin
                m_disp   = bus.load ? bus.result : m_pend;
                m_pend_v = 0;
                m_show   = 1;
                m_elem   = 2'd0;
                m_dwell  = 0;
                m_nreq   = 0;
            end else if (m_show) begin
                if (m_nreq || bus.next) begin
                    m_elem  = m_elem + 2'd1;
                    m_nreq  = 0;
                    m_dwell = 0;
                end else if (bus.auto) begin
                    if (m_dwell == 2) begin
                        m_elem  = m_elem + 2'd1;
                        m_dwell = 0;
                    end else begin
                        m_dwell = m_dwell + 1;
                    end
                end else begin
                    m_dwell = 0;
                end
            end
        end else begin
            if (bus.load) begin
                m_pend   = bus.result;
                m_pend_v = 1;
            end
            if (bus.next && m_show) m_nreq = 1;
        end

        e.tag = phase;
        e.val = {an_e, seg_e, dp_e, m_elem, fe};
        sb.push_back(e);

        @(posedge clk);
        cyc++;
        @(negedge clk);
        e = sb.pop_front();
        check(e.tag, snap(), e.val);
        bus.load = 1'b0;
        bus.next = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the pre-edge counter position within the frame equals r (bounded).
    task automatic run_until(input int r);
        for (int i = 0; (i < 64) && ((cyc % 32) != r); i++) step();
    endtask

    task automatic pulse_next();
        bus.next = 1'b1;
        step();
    endtask

    task automatic do_load(input logic [63:0] v);
        bus.result = v;
        bus.load   = 1'b1;
        step();
    endtask

    initial begin
        hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst        = 1'b0;
        bus.load   = 1'b0;
        bus.result = '0;
        bus.auto   = 1'b0;
        bus.next   = 1'b0;
        model_reset();

        phase = "reset_hold";
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(phase, snap(), SNAP_RST);
        end
        rst = 1'b1;

        // Empty display: dashes, next/auto ignored.
        phase = "empty";
        run(10);
        pulse_next();
        bus.auto = 1'b1;
        run(40);
        bus.auto = 1'b0;
        run(30);

        phase = "load_first";
        do_load(64'h0000_0000_0000_A3F1);
        run_until(0);
        run(40);

        // Two next pulses in one frame give a single advance.
        phase = "manual_next";
        run_until(10);
        pulse_next();
        run(5);
        pulse_next();
        run_until(0);
        run(40);

        phase = "two_loads";
        run_until(5);
        do_load(64'h1111_2222_3333_4444);
        run(8);
        do_load(64'hFEDC_BA98_7654_3210);
        run_until(0);
        run(33);
        for (int k = 0; k < 3; k++) begin
            run_until(12);
            pulse_next();
            run_until(0);
            run(33);
        end

        phase = "auto_cycle";
        bus.auto = 1'b1;
        run(32 * 7);
        pulse_next();
        run(32 * 5);
        bus.auto = 1'b0;
        run(40);

        // Load coincident with the frame-end transfer goes straight to the display.
        phase = "load_at_frame_end";
        run_until(31);
        do_load(64'h0F1E_2D3C_4B5A_6978);
        run(20);
        pulse_next();
        run_until(0);
        run(70);

        phase = "reset_mid";
        run_until(21);
        rst = 1'b0;
        #1;
        check("reset_mid_immediate", snap(), SNAP_RST);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_mid_hold", snap(), SNAP_RST);
        end
        rst = 1'b1;
        model_reset();
        phase = "after_reset";
        run(70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
